// File: rtl/wb_uart_master_if.sv
// rtl/wb_uart_master_if.sv - Wishbone classic single-word bus bundle for the UART debug master
interface wb_uart_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_uart_master.sv
// rtl/wb_uart_master.sv - UART byte-stream to Wishbone bridge for host peek/poke
// One command frame yields one single-word bus cycle and a status (+read data) response.
module wb_uart_master #(
  parameter int unsigned FRAME_TIMEOUT = 1000000,
  parameter int unsigned BUS_TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_overrun,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  wb_uart_master_if.master wb,
  output logic             busy
);
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ST_ACK = 8'h06;
  localparam logic [7:0] ST_TMO = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [31:0] rdata;
  logic [31:0] frame_cnt;
  logic [31:0] bus_cnt;
  logic        we;
  logic        cyc;
  logic [1:0]  byte_cnt;
  logic [7:0]  status;
  logic [2:0]  tx_left;
  logic        frame_expired;
  logic        bus_expired;

  assign wb.wb_adr_o = adr;
  assign wb.wb_dat_o = dat;
  assign wb.wb_we_o  = we;
  assign wb.wb_cyc_o = cyc;
  assign wb.wb_stb_o = cyc;
  assign wb.wb_sel_o = 4'hF;
  assign busy        = (state != IDLE);

  // Counters run from 0, so the last permitted cycle is LIMIT-1; a limit of 0 never expires.
  assign frame_expired = (FRAME_TIMEOUT != 0) && (frame_cnt == FRAME_TIMEOUT - 1);
  assign bus_expired   = (BUS_TIMEOUT != 0) && (bus_cnt == BUS_TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      adr        <= '0;
      dat        <= '0;
      rdata      <= '0;
      frame_cnt  <= '0;
      bus_cnt    <= '0;
      we         <= 1'b0;
      cyc        <= 1'b0;
      byte_cnt   <= '0;
      status     <= '0;
      tx_left    <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_valid && (state == BUS || state == RESP);
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
            we        <= (rx_data == CMD_WR);
            byte_cnt  <= '0;
            frame_cnt <= '0;
            state     <= ADDR;
          end
        end
        ADDR, DATA: begin
          if (rx_valid) begin
            frame_cnt <= '0;
            byte_cnt  <= byte_cnt + 2'd1;
            if (state == ADDR) begin
              adr <= {adr[23:0], rx_data};
            end else begin
              dat <= {dat[23:0], rx_data};
            end
            if (byte_cnt == 2'd3) begin
              if (state == ADDR && we) begin
                state <= DATA;
              end else begin
                state   <= BUS;
                cyc     <= 1'b1;
                bus_cnt <= '0;
              end
            end
          end else if (frame_expired) begin
            state <= IDLE;
          end else begin
            frame_cnt <= frame_cnt + 32'd1;
          end
        end
        BUS: begin
          // An ack on the expiry cycle still counts as success.
          if (wb.wb_ack_i) begin
            rdata  <= wb.wb_dat_i;
            status <= ST_ACK;
            cyc    <= 1'b0;
            state  <= RESP;
          end else if (bus_expired) begin
            status <= ST_TMO;
            cyc    <= 1'b0;
            state  <= RESP;
          end else begin
            bus_cnt <= bus_cnt + 32'd1;
          end
        end
        RESP: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= status;
            tx_left  <= (status == ST_ACK && !we) ? 3'd4 : 3'd0;
          end else if (tx_ready) begin
            if (tx_left == 3'd0) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_data <= rdata[31:24];
              rdata   <= {rdata[23:0], 8'h00};
              tx_left <= tx_left - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_uart_master.sv
// tb/tb_wb_uart_master.sv - Self-checking bench for wb_uart_master
module tb_wb_uart_master;
  localparam int unsigned FT = 40;
  localparam int unsigned BT = 16;

  typedef struct {
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          ack_dly;
    logic [7:0]  exp_status;
    int          exp_len;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic        chk_dat;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_overrun;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        slave_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] slave_dat = 32'h0;
  logic [31:0] slave_rdata = 32'h0;
  int          slave_delay = -1;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int last_rx_n = 0;
  int rise_lat = 0;
  int last_len = 0;
  int bus_starts = 0;
  int tx_hs = 0;
  int ovr_cnt = 0;

  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];
  vec_t       vecs[6];

  wb_uart_master_if wb();
  assign wb.wb_ack_i = slave_ack | stray_ack;
  assign wb.wb_dat_i = slave_dat;

  wb_uart_master #(.FRAME_TIMEOUT(FT), .BUS_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb(wb), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; last_rx_n = cyc_n;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic wr, input logic [31:0] adr, input logic [31:0] dat);
    send_byte(wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n && busy !== 1'b0; i++) @(negedge clk);
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", 32'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, tx_valid, rx_overrun, busy}), 32'd0);
    check("rst_adr", wb.wb_adr_o, 32'd0);
    check("rst_dat", wb.wb_dat_o, 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("sel", 32'(wb.wb_sel_o), 32'hF);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bus_t b;
    b = '{v.adr, v.wdat, v.wr, v.wr};
    slave_delay = v.ack_dly;
    slave_rdata = v.rdat;
    exp_bus.push_back(b);
    exp_tx.push_back(v.exp_status);
    if (!v.wr && v.exp_status == 8'h06)
      for (int i = 3; i >= 0; i--) exp_tx.push_back(v.rdat[i*8 +: 8]);
    send_frame(v.wr, v.adr, v.wdat);
    wait_idle(400);
    check("cyc_rise_latency", 32'(rise_lat), 32'd1);
    check("cyc_len", 32'(last_len), 32'(v.exp_len));
    check("tx_remaining", 32'(exp_tx.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs0;
    int hs0;
    int ovr0;
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0000_0000,  2, 8'h06,  3};
    vecs[1] = '{1'b0, 32'h2000_0000, 32'h0000_0000, 32'h1234_5678,  0, 8'h06,  1};
    vecs[2] = '{1'b0, 32'h1000_0010, 32'h0000_0000, 32'h1111_1111, -1, 8'h15, 16};
    vecs[3] = '{1'b1, 32'h4000_0000, 32'h0000_0001, 32'h0000_0000, -1, 8'h15, 16};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hA5A5_0F0F, 15, 8'h06, 16};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000,  0, 8'h06,  1};

    fork
      begin : slave_proc
        int scnt = 0;
        forever begin
          @(negedge clk);
          if (wb.wb_cyc_o === 1'b1 && !slave_ack) begin
            if (scnt == slave_delay) begin
              slave_ack = 1'b1;
              slave_dat = slave_rdata;
            end
            scnt++;
          end else begin
            slave_ack = 1'b0;
            scnt = 0;
          end
        end
      end
      begin : tx_mon
        logic [7:0] prev_d = 8'h00;
        logic prev_pend = 1'b0;
        forever begin
          @(negedge clk);
          if (prev_pend && reset !== 1'b1)
            check("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_d}));
          if (reset !== 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            tx_hs++;
            if (exp_tx.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL tx_unexpected actual=%h required=none", tx_data);
            end else begin
              check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
          end
          prev_pend = (tx_valid === 1'b1) && (tx_ready !== 1'b1) && (reset !== 1'b1);
          prev_d = tx_data;
        end
      end
      begin : bus_mon
        logic prev_cyc = 1'b0;
        int cur_len = 0;
        bus_t e;
        forever begin
          @(negedge clk);
          if (rx_overrun === 1'b1) ovr_cnt++;
          if (wb.wb_cyc_o === 1'b1) begin
            if (!prev_cyc) begin
              bus_starts++;
              rise_lat = cyc_n - last_rx_n;
              cur_len = 0;
              if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected actual=%h required=none", wb.wb_adr_o);
              end else begin
                e = exp_bus.pop_front();
                check("bus_adr", wb.wb_adr_o, e.adr);
                check("bus_we", 32'(wb.wb_we_o), 32'(e.we));
                check("bus_sel_stb", 32'({wb.wb_sel_o, wb.wb_stb_o}), 32'h1F);
                if (e.chk_dat) check("bus_dat", wb.wb_dat_o, e.dat);
              end
            end
            cur_len++;
          end else if (prev_cyc) begin
            last_len = cur_len;
          end
          prev_cyc = (wb.wb_cyc_o === 1'b1);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 reset = 1'b0;

    // Ack while idle must be ignored.
    @(posedge clk); #1 stray_ack = 1'b1;
    @(posedge clk); #1 stray_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_busy", 32'(busy), 32'd0);
    check("stray_ack_no_cycle", 32'(bus_starts), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Junk byte, partial read frame, then silence past the frame timeout.
    bs0 = bus_starts;
    hs0 = tx_hs;
    send_byte(8'hAA);
    send_byte(8'h52);
    send_byte(8'h20);
    send_byte(8'h00);
    repeat (30) @(negedge clk);
    check("frame_pending_busy", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    check("frame_timeout_idle", 32'(busy), 32'd0);
    check("frame_timeout_no_bus", 32'(bus_starts), 32'(bs0));
    check("frame_timeout_no_tx", 32'(tx_hs), 32'(hs0));
    run_vec(vecs[1]);

    // Transmitter stall mid-response with an overrun byte.
    @(posedge clk); #1 tx_ready = 1'b0;
    slave_delay = 1;
    slave_rdata = 32'hCAFE_F00D;
    exp_bus.push_back('{32'h5000_0008, 32'h0, 1'b0, 1'b0});
    exp_tx.push_back(8'h06); exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
    exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
    send_frame(1'b0, 32'h5000_0008, 32'h0);
    for (int i = 0; i < 100 && tx_valid !== 1'b1; i++) @(negedge clk);
    check("stall_tx_valid", 32'(tx_valid), 32'd1);
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    ovr0 = ovr_cnt;
    repeat (3) @(negedge clk);
    send_byte(8'h57);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle(100);
    check("overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    check("stall_tx_remaining", 32'(exp_tx.size()), 32'd0);

    // Reset while the bus cycle is open.
    slave_delay = -1;
    exp_bus.push_back('{32'h6000_0000, 32'h0, 1'b0, 1'b0});
    send_frame(1'b0, 32'h6000_0000, 32'h0);
    for (int i = 0; i < 20 && wb.wb_cyc_o !== 1'b1; i++) @(negedge clk);
    check("mid_bus_cyc_seen", 32'(wb.wb_cyc_o), 32'd1);
    repeat (3) @(negedge clk);
    reset_pulse();

    // Reset while a response is waiting on the transmitter.
    @(posedge clk); #1 tx_ready = 1'b0;
    slave_delay = 0;
    slave_rdata = 32'h0BAD_0BAD;
    exp_bus.push_back('{32'h7000_0000, 32'h0, 1'b0, 1'b0});
    send_frame(1'b0, 32'h7000_0000, 32'h0);
    for (int i = 0; i < 100 && tx_valid !== 1'b1; i++) @(negedge clk);
    check("mid_resp_tx_valid", 32'(tx_valid), 32'd1);
    reset_pulse();
    @(posedge clk); #1 tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 32'({busy, tx_valid}), 32'd0);

    run_vec(vecs[0]);
    check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
